data_cache_ctrl: RTL and testbench
==================================

Name: data_cache_ctrl

Overview:
- Controller that sits between the CPU load/store stage and the direct-mapped data cache storage array.
- Drives the storage array's set, write-data and write-enable inputs, and reads its valid, tag and read-data outputs. Those outputs are registered, so reads have 1-cycle latency.
- Performs the tag compare and handles misses through a req/ack handshake to main memory.
- Write-through, no-write-allocate, one 32-bit word per line; after reset it sweeps every set invalid.

Parameters:
- ADDRESS_WIDTH, 32, CPU/memory byte address width
- DATA_WIDTH, 32, word width
- SET_WIDTH, 3, set index bits (8 sets)
- TAG_WIDTH, 27, ADDRESS_WIDTH-SET_WIDTH-2
- CNT_WIDTH, 16, performance counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; sampled only while cpu_ready=1
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_ready  out  1  controller idle, can accept a request
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_done=1 for a load
- cache_set  out  SET_WIDTH  set index to storage
- cache_we  out  1  storage write enable
- cache_wv  out  1  valid bit to write
- cache_wtag  out  TAG_WIDTH  tag to write
- cache_wdata  out  DATA_WIDTH  data to write
- cache_v  in  1  stored valid bit, registered (1-cycle read)
- cache_tag  in  TAG_WIDTH  stored tag
- cache_rdata  in  DATA_WIDTH  stored data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDRESS_WIDTH  word-aligned address, bits [1:0]=0
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- hit_count  out  CNT_WIDTH  count of lookup hits (loads and stores), wraps
- miss_count  out  CNT_WIDTH  count of lookup misses, wraps

Behaviour:
- Address split: set = addr[SET_WIDTH+1:2], tag = addr[ADDRESS_WIDTH-1:SET_WIDTH+2].
- Reset (async, rst_n=0):
  - State goes to INIT; sweep index = 0.
  - All outputs 0, including counters and cpu_rdata.
  - mem_req falls immediately, even mid-handshake; the in-flight transaction is abandoned.
- INIT:
  - Runs for 2^SET_WIDTH cycles.
  - cache_we=1, cache_wv=0, cache_set=index; index increments each cycle.
  - At index=max, go to IDLE.
  - cpu_ready=0 throughout.
- IDLE:
  - cpu_ready=1; cache_set=cpu_addr set field, combinationally.
  - On cpu_req=1, latch addr, we and wdata, then go to LOOKUP.
- LOOKUP (storage outputs are now valid):
  - hit = cache_v & (cache_tag == latched tag). Exactly one of hit_count/miss_count increments.
  - Load hit: cpu_rdata <= cache_rdata, cpu_done pulse next cycle, go to IDLE. Request-to-done latency is 2 cycles.
  - Load miss: go to MEM_RD.
  - Store hit: cache_we=1, cache_wv=1, cache_wtag=tag, cache_wdata=wdata this cycle, then go to MEM_WR.
  - Store miss: no cache write, go to MEM_WR.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr=latched addr with [1:0] cleared.
  - On mem_ack:
    - cache_we=1, wv=1, wtag=tag, wdata=mem_rdata (same cycle).
    - cpu_rdata <= mem_rdata; cpu_done next cycle.
    - Go to IDLE.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_wdata=latched wdata.
  - On mem_ack: cpu_done next cycle, go to IDLE.
- Fixed response rules:
  - mem_ack is ignored outside MEM_RD/MEM_WR.
  - mem_req, mem_addr and mem_wdata are stable while waiting for ack.
  - cpu_req is ignored outside IDLE; no queuing.
  - cpu_done is asserted for exactly 1 cycle per accepted request; cpu_ready is 0 in that cycle. The controller re-enters IDLE after it.
  - cpu_rdata holds its value until the next load completes.
  - Back-to-back requests: the first can be accepted in the cycle after cpu_done.
  - Counters wrap at 2^CNT_WIDTH-1 -> 0.

Decomposition:
- Package dcache_pkg holds:
  - state enum {INIT, IDLE, LOOKUP, MEM_RD, MEM_WR, DONE}
  - default width localparams
  - functions get_set(addr) and get_tag(addr)
- No sub-module required. The two counters may be one small sub-module, wrap_counter, instantiated twice.

Test Plan:
- Reset release -> cpu_ready=0 for 8 cycles, cache_we=1 with cache_wv=0 and cache_set 0..7, then cpu_ready=1.
- Load 0x0000_0010 on a cold cache, memory acks after 3 cycles with 0xDEADBEEF:
  - mem_req held 3 cycles, mem_addr=0x10.
  - Refill write to set 4 with tag 0 and V=1.
  - cpu_rdata=0xDEADBEEF, cpu_done once, miss_count=1.
- Repeat load 0x10 with the storage model returning V=1, tag 0 -> no mem_req, cpu_done 2 cycles after request, rdata=0xDEADBEEF, hit_count=1.
- Store 0x55AA to 0x10 (hit) -> cache write with data 0x55AA, then mem write 0x10/0x55AA. Store to 0x30 (miss, set 4, tag 1) -> no cache_we, mem write only.
- Drop rst_n mid MEM_RD -> mem_req=0 in the same cycle, counters 0, INIT sweep restarts, and a stale mem_ack after reset is ignored.
- Drive mem_ack while idle and cpu_req during MEM_WR -> both ignored; exactly one cpu_done per accepted request.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, default widths and address helpers for the data cache controller
package dcache_pkg;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_SET_WIDTH     = 3;
    localparam int DEF_TAG_WIDTH     = DEF_ADDRESS_WIDTH - DEF_SET_WIDTH - 2;
    localparam int DEF_CNT_WIDTH     = 16;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [DEF_SET_WIDTH-1:0] get_set(input logic [DEF_ADDRESS_WIDTH-1:0] addr);
        return addr[DEF_SET_WIDTH+1:2];
    endfunction

    function automatic logic [DEF_TAG_WIDTH-1:0] get_tag(input logic [DEF_ADDRESS_WIDTH-1:0] addr);
        return addr[DEF_ADDRESS_WIDTH-1:DEF_SET_WIDTH+2];
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enable-gated event counter that wraps to zero
module wrap_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped, write-through, no-write-allocate data cache controller
import dcache_pkg::*;

module data_cache_ctrl #(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SET_WIDTH     = DEF_SET_WIDTH,
    parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_done,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic [SET_WIDTH-1:0]     cache_set,
    output logic                     cache_we,
    output logic                     cache_wv,
    output logic [TAG_WIDTH-1:0]     cache_wtag,
    output logic [DATA_WIDTH-1:0]    cache_wdata,
    input  logic                     cache_v,
    input  logic [TAG_WIDTH-1:0]     cache_tag,
    input  logic [DATA_WIDTH-1:0]    cache_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);

    state_t                   state;
    state_t                   state_nx;
    logic [SET_WIDTH-1:0]     init_idx;
    logic [ADDRESS_WIDTH-3:0] req_word;
    logic                     req_we;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic [SET_WIDTH-1:0]     req_set;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic                     hit;
    logic                     hit_inc;
    logic                     miss_inc;

    assign req_set  = get_set({req_word, 2'b00});
    assign req_tag  = get_tag({req_word, 2'b00});
    assign hit      = cache_v && (cache_tag == req_tag);
    assign hit_inc  = (state == ST_LOOKUP) && hit;
    assign miss_inc = (state == ST_LOOKUP) && !hit;

    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT:   if (init_idx == '1) state_nx = ST_IDLE;
            ST_IDLE:   if (cpu_req) state_nx = ST_LOOKUP;
            ST_LOOKUP: begin
                if (req_we)   state_nx = ST_MEM_WR;
                else if (hit) state_nx = ST_DONE;
                else          state_nx = ST_MEM_RD;
            end
            ST_MEM_RD: if (mem_ack) state_nx = ST_DONE;
            ST_MEM_WR: if (mem_ack) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_idx  <= '0;
            req_word  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) begin
                init_idx <= init_idx + SET_WIDTH'(1);
            end
            if (state == ST_IDLE && cpu_req) begin
                req_word  <= cpu_addr[ADDRESS_WIDTH-1:2];
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (state == ST_LOOKUP && !req_we && hit) begin
                cpu_rdata <= cache_rdata;
            end else if (state == ST_MEM_RD && mem_ack) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    // The sweep write is qualified by rst_n so the array is left untouched while reset is held.
    always_comb begin
        cache_set   = req_set;
        cache_we    = 1'b0;
        cache_wv    = 1'b0;
        cache_wtag  = '0;
        cache_wdata = '0;
        case (state)
            ST_INIT: begin
                cache_set = init_idx;
                cache_we  = rst_n;
            end
            ST_IDLE: begin
                cache_set = get_set(cpu_addr);
            end
            ST_LOOKUP: begin
                if (req_we && hit) begin
                    cache_we    = 1'b1;
                    cache_wv    = 1'b1;
                    cache_wtag  = req_tag;
                    cache_wdata = req_wdata;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    cache_we    = 1'b1;
                    cache_wv    = 1'b1;
                    cache_wtag  = req_tag;
                    cache_wdata = mem_rdata;
                end
            end
            default: begin
                cache_set = req_set;
            end
        endcase
    end

    assign cpu_ready = (state == ST_IDLE);
    assign cpu_done  = (state == ST_DONE);
    assign mem_req   = (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign mem_we    = (state == ST_MEM_WR);
    assign mem_addr  = mem_req ? {req_word, 2'b00} : '0;
    assign mem_wdata = mem_we ? req_wdata : '0;

    wrap_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hit_inc),
        .count (hit_count)
    );

    wrap_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb/tb_data_cache_ctrl.sv - scoreboard bench for data_cache_ctrl with storage and memory models
module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic [2:0]  cache_set;
    logic        cache_we;
    logic        cache_wv;
    logic [26:0] cache_wtag;
    logic [31:0] cache_wdata;
    logic        cache_v = 1'b0;
    logic [26:0] cache_tag = '0;
    logic [31:0] cache_rdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    data_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cache_set(cache_set), .cache_we(cache_we), .cache_wv(cache_wv),
        .cache_wtag(cache_wtag), .cache_wdata(cache_wdata),
        .cache_v(cache_v), .cache_tag(cache_tag), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] hits;
        logic [15:0] misses;
        int          lat;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          cycles;
    } mem_exp_t;

    typedef struct {
        logic [2:0]  set;
        logic [26:0] tag;
        logic [31:0] data;
    } cw_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    cw_exp_t  cw_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int req_cyc = 0;
    int ack_delay = 1;
    int resp_en = 1;
    int req_cycles = 0;
    logic [31:0] rd_data = '0;

    logic        st_v [8];
    logic [26:0] st_tag [8];
    logic [31:0] st_data [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            st_v[i] = 1'b0;
            st_tag[i] = '0;
            st_data[i] = '0;
        end
    end

    // Storage array with registered read and read-before-write behaviour
    always @(posedge clk) begin
        cache_v     <= st_v[cache_set];
        cache_tag   <= st_tag[cache_set];
        cache_rdata <= st_data[cache_set];
        if (cache_we) begin
            st_v[cache_set]    <= cache_wv;
            st_tag[cache_set]  <= cache_wtag;
            st_data[cache_set] <= cache_wdata;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                wait_cnt = 0;
            end else if (mem_req && resp_en != 0) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_data;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // CPU completion monitor
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_done) begin
                if (cpu_q.size() == 0) begin
                    fail("cpu_done_unexpected");
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
                    chk("hit_count", 64'(hit_count), 64'(e.hits));
                    chk("miss_count", 64'(miss_count), 64'(e.misses));
                    chk("ready_during_done", 64'(cpu_ready), 64'(0));
                    chk("latency", 64'(cyc - req_cyc), 64'(e.lat));
                end
            end
        end
    end

    // Memory transaction monitor
    initial begin
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                if (mem_ack) begin
                    if (mem_q.size() == 0) begin
                        fail("mem_txn_unexpected");
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_we", 64'(mem_we), 64'(m.we));
                        chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                        if (m.we) chk("mem_wdata", 64'(mem_wdata), 64'(m.data));
                        chk("mem_req_cycles", 64'(req_cycles), 64'(m.cycles));
                    end
                    req_cycles = 0;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    // Valid-line cache write monitor
    initial begin
        cw_exp_t w;
        forever begin
            @(negedge clk);
            if (rst_n && cache_we && cache_wv) begin
                if (cw_q.size() == 0) begin
                    fail("cache_write_unexpected");
                end else begin
                    w = cw_q.pop_front();
                    chk("cache_set", 64'(cache_set), 64'(w.set));
                    chk("cache_wtag", 64'(cache_wtag), 64'(w.tag));
                    chk("cache_wdata", 64'(cache_wdata), 64'(w.data));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) fail("issue_timeout");
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        req_cyc   = cyc;
        @(negedge clk);
        cpu_req   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(cpu_ready && cpu_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!(cpu_ready && cpu_q.size() == 0)) fail("wait_idle_timeout");
    endtask

    task automatic sweep_check();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("init_ready", 64'(cpu_ready), 64'(0));
            chk("init_we", 64'(cache_we), 64'(1));
            chk("init_wv", 64'(cache_wv), 64'(0));
            chk("init_set", 64'(cache_set), 64'(i));
        end
        @(negedge clk);
        chk("ready_after_init", 64'(cpu_ready), 64'(1));
    endtask

    task automatic exp_cpu(input logic [31:0] rdata, input int hits, input int misses, input int lat);
        cpu_exp_t e;
        e.rdata = rdata; e.hits = 16'(hits); e.misses = 16'(misses); e.lat = lat;
        cpu_q.push_back(e);
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] data, input int cycles);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.data = data; m.cycles = cycles;
        mem_q.push_back(m);
    endtask

    task automatic exp_cw(input logic [2:0] set, input logic [26:0] tag, input logic [31:0] data);
        cw_exp_t w;
        w.set = set; w.tag = tag; w.data = data;
        cw_q.push_back(w);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(cpu_ready), 64'(0));
        chk("rst_done", 64'(cpu_done), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_cache_we", 64'(cache_we), 64'(0));
        chk("rst_rdata", 64'(cpu_rdata), 64'(0));
        chk("rst_hits", 64'(hit_count), 64'(0));
        chk("rst_misses", 64'(miss_count), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        sweep_check();

        // Cold load miss with a 3-cycle memory response
        ack_delay = 3; rd_data = 32'hDEADBEEF;
        exp_mem(1'b0, 32'h10, 32'h0, 3);
        exp_cw(3'd4, 27'd0, 32'hDEADBEEF);
        exp_cpu(32'hDEADBEEF, 0, 1, 5);
        issue(1'b0, 32'h0000_0010, 32'h0);
        wait_idle();

        // Repeat load hits with no memory traffic
        exp_cpu(32'hDEADBEEF, 1, 1, 2);
        issue(1'b0, 32'h10, 32'h0);
        wait_idle();

        // Store hit: cache update then write-through
        ack_delay = 2;
        exp_cw(3'd4, 27'd0, 32'h55AA);
        exp_mem(1'b1, 32'h10, 32'h55AA, 2);
        exp_cpu(32'hDEADBEEF, 2, 1, 4);
        issue(1'b1, 32'h10, 32'h55AA);
        wait_idle();

        // Store miss to the same set with another tag: memory only
        ack_delay = 1;
        exp_mem(1'b1, 32'h30, 32'h1234, 1);
        exp_cpu(32'hDEADBEEF, 2, 2, 3);
        issue(1'b1, 32'h30, 32'h1234);
        wait_idle();

        exp_cpu(32'h55AA, 3, 2, 2);
        issue(1'b0, 32'h10, 32'h0);
        wait_idle();

        // Load miss with unaligned address bits set; memory sees the aligned word
        ack_delay = 2; rd_data = 32'hCAFEF00D;
        exp_mem(1'b0, 32'h30, 32'h0, 2);
        exp_cw(3'd4, 27'd1, 32'hCAFEF00D);
        exp_cpu(32'hCAFEF00D, 3, 3, 4);
        issue(1'b0, 32'h33, 32'h0);
        wait_idle();

        // Stray mem_ack while idle
        resp_en = 0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_ready", 64'(cpu_ready), 64'(1));
        chk("idle_ack_mem_req", 64'(mem_req), 64'(0));
        chk("idle_ack_hits", 64'(hit_count), 64'(3));
        chk("idle_ack_misses", 64'(miss_count), 64'(3));
        resp_en = 1;

        // cpu_req held during MEM_WR is ignored
        ack_delay = 6;
        exp_mem(1'b1, 32'h44, 32'h77, 6);
        exp_cpu(32'hCAFEF00D, 3, 4, 8);
        issue(1'b1, 32'h44, 32'h77);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        cpu_req = 1'b0;
        wait_idle();

        // Reset in the middle of a memory read
        resp_en = 0;
        issue(1'b0, 32'h50, 32'h0);
        repeat (2) @(negedge clk);
        chk("mid_rd_mem_req", 64'(mem_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", 64'(mem_req), 64'(0));
        chk("async_ready", 64'(cpu_ready), 64'(0));
        chk("async_hits", 64'(hit_count), 64'(0));
        chk("async_misses", 64'(miss_count), 64'(0));
        chk("async_rdata", 64'(cpu_rdata), 64'(0));
        chk("async_cache_we", 64'(cache_we), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ack = 1'b1;
        sweep_check();
        resp_en = 1;

        // Sweep invalidated the line, so this misses again
        ack_delay = 2; rd_data = 32'h0BADF00D;
        exp_mem(1'b0, 32'h10, 32'h0, 2);
        exp_cw(3'd4, 27'd0, 32'h0BADF00D);
        exp_cpu(32'h0BADF00D, 0, 1, 4);
        issue(1'b0, 32'h10, 32'h0);
        wait_idle();

        exp_cpu(32'h0BADF00D, 1, 1, 2);
        issue(1'b0, 32'h10, 32'h0);
        wait_idle();

        repeat (4) @(negedge clk);
        chk("cpu_q_empty", 64'(cpu_q.size()), 64'(0));
        chk("mem_q_empty", 64'(mem_q.size()), 64'(0));
        chk("cw_q_empty", 64'(cw_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
